// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// The source drives byte_in/byte_valid; the loader answers with byte_ready.
interface imem_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed big-endian byte stream and writes it into
// instruction memory, holding the core in reset until the whole image is written.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q,  state_d;
  logic [1:0]         lane_q,   lane_d;
  logic [31:0]        count_q,  count_d;
  logic [23:0]        word_q,   word_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic               we_q,     we_d;
  logic [31:0]        addr_q,   addr_d;
  logic [31:0]        wdata_q,  wdata_d;
  logic [31:0]        sum_q,    sum_d;
  logic               ready_q,  ready_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               err_q,    err_d;
  logic               cpurst_q, cpurst_d;

  logic               accept;
  logic [31:0]        len_full;
  logic [31:0]        word_full;

  assign accept    = bus.byte_valid & ready_q;
  assign len_full  = {count_q[23:0], bus.byte_in};
  assign word_full = {word_q, bus.byte_in};

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    count_d = count_q;
    word_d  = word_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sum_d   = sum_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          lane_d  = 2'd0;
          count_d = 32'd0;
          idx_d   = '0;
          sum_d   = 32'd0;
        end
      end

      S_LEN: begin
        if (accept) begin
          count_d = len_full;
          lane_d  = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            if (len_full == 32'd0) begin
              state_d = S_DONE;
            end else if (len_full > 32'(DEPTH_WORDS)) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d = word_full[23:0];
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // Write strobe lands one cycle later; index advances now so the next
            // word's address is ready even with back-to-back bytes.
            we_d    = 1'b1;
            addr_d  = ADDR_BASE + (32'(idx_q) << 2);
            wdata_d = word_full;
            sum_d   = sum_q + word_full;
            idx_d   = idx_q + IDX_W'(1);
            if ((32'(idx_q) + 32'd1) == count_q) begin
              state_d = S_DONE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they are registered.
    ready_d  = (state_d == S_LEN) || (state_d == S_DATA);
    busy_d   = (state_d == S_LEN) || (state_d == S_DATA);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
    cpurst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      lane_q   <= 2'd0;
      count_q  <= 32'd0;
      word_q   <= 24'd0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= ADDR_BASE;
      wdata_q  <= 32'd0;
      sum_q    <= 32'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cpurst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      count_q  <= count_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sum_q    <= sum_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cpurst_q <= cpurst_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign imem_we        = we_q;
  assign imem_addr      = addr_q;
  assign imem_wdata     = wdata_q;
  assign checksum       = sum_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign cpu_reset      = cpurst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a driver streams images, a scoreboard queue
// holds the writes the image implies, and a monitor checks each imem_we pulse.
module tb_imem_loader;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  imem_loader_if sif ();

  imem_loader #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_BASE   (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (sif),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] img[$];
  int          checks  = 0;
  int          errors  = 0;
  int          nwrites = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      exp_t e;
      nwrites++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual addr=%h data=%h required none", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e.a);
        chk("write_data", imem_wdata, e.d);
        $display("write addr=%h data=%h", imem_addr, imem_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      sif.byte_valid = 1'b0;
      step();
    end
    sif.byte_valid = 1'b1;
    sif.byte_in    = b;
    n = 0;
    while (!sif.byte_ready && n < 20) begin
      step();
      n++;
    end
    if (!sif.byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: actual=0 required=1");
      sif.byte_valid = 1'b0;
      return;
    end
    step();
    sif.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[8*k +: 8], int'($urandom_range(gmax, gmin)));
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 50) begin
      step();
      n++;
    end
    chk("end_timeout", {31'd0, done | error}, 32'd1);
  endtask

  // Reference: word i goes to BASE + 4*i, checksum is the plain sum of words.
  task automatic load_image(input int gmin, input int gmax, input bit mid_start);
    int          n;
    logic [31:0] sum;
    n   = img.size();
    sum = 32'd0;
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("cpu_reset_loading", {31'd0, cpu_reset}, 32'd1);
    send_word(32'(n), gmin, gmax);
    if (mid_start && n > 0) begin
      pulse_start();
      chk("start_ignored_busy", {31'd0, busy}, 32'd1);
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_t'{a: BASE + 32'(4 * i), d: img[i]});
      sum = sum + img[i];
      send_word(img[i], gmin, gmax);
    end
    if (n > 0) chk("ready_after_last", {31'd0, sif.byte_ready}, 32'd0);
    wait_end();
    step();
    chk("done", {31'd0, done}, 32'd1);
    chk("error_clear", {31'd0, error}, 32'd0);
    chk("cpu_reset_released", {31'd0, cpu_reset}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("checksum", checksum, sum);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    $display("load words=%0d checksum=%h", n, checksum);
  endtask

  task automatic chk_reset_vals();
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_ready", {31'd0, sif.byte_ready}, 32'd0);
  endtask

  initial begin
    int w0;
    sif.byte_valid = 1'b0;
    sif.byte_in    = 8'h00;
    repeat (3) step();
    chk_reset_vals();
    reset = 1'b1;
    step();

    // Two-word directed image, valid held high.
    img = '{32'h1234_5678, 32'h9ABC_DEF0};
    load_image(0, 0, 1'b0);
    chk("checksum_const", checksum, 32'hACF1_3568);

    // Empty image.
    w0  = nwrites;
    img = '{};
    load_image(0, 0, 1'b0);
    chk("empty_no_write", 32'(nwrites - w0), 32'd0);

    // Oversize length, then stream held valid must not be consumed.
    w0 = nwrites;
    pulse_start();
    send_word(DEPTH + 1, 0, 0);
    chk("err_flag", {31'd0, error}, 32'd1);
    chk("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("err_ready", {31'd0, sif.byte_ready}, 32'd0);
    chk("err_done", {31'd0, done}, 32'd0);
    sif.byte_valid = 1'b1;
    sif.byte_in    = 8'hA5;
    repeat (5) step();
    sif.byte_valid = 1'b0;
    chk("err_still_ready0", {31'd0, sif.byte_ready}, 32'd0);
    chk("err_no_write", 32'(nwrites - w0), 32'd0);
    img = '{$urandom()};
    load_image(0, 1, 1'b0);

    // One word, valid toggling every cycle, start pulsed mid-load.
    img = '{$urandom()};
    load_image(1, 1, 1'b1);

    // Randomised images.
    for (int t = 0; t < 6; t++) begin
      img = '{};
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) img.push_back($urandom());
      load_image(0, 2, t[0]);
    end

    // Reset after 6 data bytes of a 3-word load.
    img = '{$urandom(), $urandom(), $urandom()};
    pulse_start();
    send_word(32'd3, 0, 1);
    exp_q.push_back(exp_t'{a: BASE, d: img[0]});
    send_word(img[0], 0, 1);
    send_byte(img[1][31:24], 0);
    send_byte(img[1][23:16], 0);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    chk("partial_writes", 32'(exp_q.size()), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    load_image(0, 1, 1'b0);

    // Reset while the write strobe of the last word is pending.
    w0 = nwrites;
    pulse_start();
    send_word(32'd1, 0, 0);
    send_word($urandom(), 0, 0);
    reset = 1'b0;
    #1;
    chk("pending_we_dropped", {31'd0, imem_we}, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("pending_no_write", 32'(nwrites - w0), 32'd0);

    // Full-capacity image: length equal to DEPTH is accepted.
    img = '{};
    for (int i = 0; i < int'(DEPTH); i++) img.push_back($urandom());
    load_image(0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=expired required=finish");
    $fatal(1, "timeout");
  end

endmodule
